fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register; sits directly upstream of the main decode Controller.
- Holds the PC and fetches from an instruction memory that answers after a variable number of cycles.
- Registers each fetched instruction and its PC+4 into IF/ID and drives Opcode[5:0] and Bit17 to the Controller.
- Handles stalls from hazard logic and branch/jump redirects from later stages.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous, active-high reset.
- ImemReq  output  1  fetch request to instruction memory.
- ImemAddr  output  32  fetch address; equals PC.
- ImemReady  input  1  one-cycle pulse: ImemRdata is valid and the request completes.
- ImemRdata  input  32  fetched instruction.
- Stall  input  1  from hazard unit: hold IF/ID and PC.
- Redirect  input  1  branch taken or jump resolved downstream.
- RedirectPC  input  32  target address; bits [1:0] are ignored and treated as 0.
- IfId_Instr  output  32  registered instruction.
- IfId_PCPlus4  output  32  registered fetch address + 4.
- IfId_Valid  output  1  1 = IfId_Instr is a real instruction.
- Opcode  output  6  IfId_Instr[31:26], combinational, to the Controller's Instruction input.
- Bit17  output  1  IfId_Instr[16], combinational; selects bgez (1) or bltz (0).

Behaviour:
- Reset, applied on any cycle and in any state:
  - PC = RESET_PC, state = FETCH.
  - IfId_Instr = 0 (nop), IfId_PCPlus4 = 0, IfId_Valid = 0.
  - Holding buffer cleared.
- Outputs during and after reset:
  - ImemReq = 0 during the reset cycle.
  - ImemReq = 1 from the first cycle after Rst deasserts.
- Request protocol:
  - ImemReq is level. ImemAddr is held stable until ImemReady.
  - Only one request is outstanding at a time.
  - ImemReady with no outstanding request is ignored.
- State FETCH (ImemReq = 1):
  - ImemReady & !Stall: IF/ID <= {ImemRdata, PC+4, valid=1}; PC <= PC+4; stay in FETCH. Best case is one instruction per cycle.
  - ImemReady & Stall: capture ImemRdata and PC+4 in the holding buffer; PC <= PC+4; go to HOLD. IF/ID is unchanged.
  - !ImemReady & !Stall: IF/ID becomes a bubble (Instr = 0, Valid = 0).
  - !ImemReady & Stall: IF/ID is unchanged.
- State HOLD (ImemReq = 0):
  - Stall: remain in HOLD; IF/ID and buffer are unchanged.
  - !Stall: IF/ID <= buffer contents with valid=1; go to FETCH. The next request is issued at the already-incremented PC.
- State DRAIN (ImemReq = 0; a killed request is still outstanding):
  - Wait for ImemReady and discard the data.
  - Then go to FETCH with PC = the redirect target.
  - IF/ID bubbles each cycle unless Stall.
- Redirect has priority over Stall and over ImemReady, in every state:
  - PC <= {RedirectPC[31:2], 2'b00}.
  - IF/ID flushed to a bubble (Instr = 0, Valid = 0).
  - Holding buffer invalidated.
  - From FETCH with the request outstanding and no ImemReady that cycle: go to DRAIN.
  - From FETCH with ImemReady in the same cycle: discard the data and stay in FETCH at the new PC.
  - From HOLD: go to FETCH.
  - In DRAIN: update PC (a later redirect wins) and stay in DRAIN.
- Arithmetic: PC+4 is a 32-bit add; wraps 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
- Bubbles: Instr = 0 decodes as sll $0 in the Controller (harmless). IfId_Valid lets downstream suppress it explicitly.
- Latency: instruction visible at IF/ID one cycle after the ImemReady it arrived on, if not stalled.

Decomposition:
- Shared package (mips_pkg):
  - Opcode constants already used by the Controller: OP_RTYPE = 6'b000000, OP_REGIMM = 6'b000001, OP_J = 6'b000010, OP_JAL = 6'b000011.
  - NOP_INSTR = 32'h0000_0000.
  - fetch_state_t enum: FETCH, HOLD, DRAIN.
- Sub-module if_id_reg: IF/ID register with load, flush and hold controls; the FSM and PC logic stay in fetch_stage.

Test Plan:
- Rst for 2 cycles, then ImemReady every cycle with data = addr|32'h2000_0000 -> ImemAddr 0,4,8. IF/ID shows 32'h2000_0000 with PCPlus4 = 4 the cycle after the first ready, Valid = 1. Opcode = 6'b001000.
- ImemReady 3 cycles after the request at PC = 8 -> ImemAddr held at 8 for all 3 cycles. IF/ID bubbles (Valid = 0, Instr = 0) while waiting.
- Stall = 1 on the ImemReady cycle for instr 32'h0401_0003 -> state HOLD, ImemReq = 0, IF/ID unchanged. Drop Stall -> IF/ID = 32'h0401_0003, Bit17 = 1, Opcode = 1.
- Redirect to 32'h0000_0103 while a request at 32'h10 is outstanding -> DRAIN. Next ImemReady data is discarded. The following ImemAddr = 32'h0000_0100 and IF/ID stays flushed.
- Redirect and Stall in the same cycle in HOLD -> IF/ID flushed (Valid = 0), buffer dropped, FETCH at the target.
- Rst asserted mid-DRAIN -> next cycle PC = RESET_PC, Valid = 0, state FETCH. A stale ImemReady is ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode constants, fetch FSM states and
// small address helpers used by the fetch stage.
package mips_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;

  localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // 32-bit wrap-around increment, no carry out.
  function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] pc);
    return pc + DATA_W'(4);
  endfunction

  function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
    return addr & ~DATA_W'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its neighbours: instruction memory,
// hazard/redirect control and the IF/ID outputs towards decode.
interface fetch_stage_if;

  logic                         ImemReq;
  logic [mips_pkg::DATA_W-1:0]  ImemAddr;
  logic                         ImemReady;
  logic [mips_pkg::DATA_W-1:0]  ImemRdata;
  logic                         Stall;
  logic                         Redirect;
  logic [mips_pkg::DATA_W-1:0]  RedirectPC;
  logic [mips_pkg::DATA_W-1:0]  IfId_Instr;
  logic [mips_pkg::DATA_W-1:0]  IfId_PCPlus4;
  logic                         IfId_Valid;
  logic [5:0]                   Opcode;
  logic                         Bit17;

  modport master (
    output ImemReq, ImemAddr, IfId_Instr, IfId_PCPlus4, IfId_Valid, Opcode, Bit17,
    input  ImemReady, ImemRdata, Stall, Redirect, RedirectPC
  );

  modport slave (
    input  ImemReq, ImemAddr, IfId_Instr, IfId_PCPlus4, IfId_Valid, Opcode, Bit17,
    output ImemReady, ImemRdata, Stall, Redirect, RedirectPC
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush inserts a nop bubble, load captures a fetched
// instruction, otherwise the contents are held.
module if_id_reg
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] instr_p0,
  input  logic [DATA_W-1:0] pc4_p0,
  output logic [DATA_W-1:0] instr_p1,
  output logic [DATA_W-1:0] pc4_p1,
  output logic              vld_p1
);

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_p1 <= NOP_INSTR;
      pc4_p1   <= '0;
      vld_p1   <= 1'b0;
    end else if (flush) begin
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (load) begin
      instr_p1 <= instr_p0;
      pc4_p1   <= pc4_p0;
      vld_p1   <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, variable-latency memory handshake, stall
// holding buffer and redirect drain, feeding the IF/ID register.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_PC = 32'h0000_0000
)
(
  input  logic           Clk,
  input  logic           Rst,
  fetch_stage_if.master  bus
);

  fetch_state_t      state;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] pc_plus4;
  logic [DATA_W-1:0] redirect_pc;
  logic [DATA_W-1:0] buf_instr;
  logic [DATA_W-1:0] buf_pc4;
  logic              req;
  logic              load;
  logic              flush;
  logic [DATA_W-1:0] ld_instr_p0;
  logic [DATA_W-1:0] ld_pc4_p0;
  logic [DATA_W-1:0] instr_p1;
  logic [DATA_W-1:0] pc4_p1;
  logic              vld_p1;

  assign pc_plus4    = pc_inc(pc);
  assign redirect_pc = word_align(bus.RedirectPC);

  // A request is outstanding exactly while FETCH is requesting; the reset
  // cycle is masked so memory never sees a request before PC is defined.
  assign req          = (state == FETCH) && !Rst;
  assign bus.ImemReq  = req;
  assign bus.ImemAddr = pc;

  always_comb begin
    load        = 1'b0;
    flush       = 1'b0;
    ld_instr_p0 = bus.ImemRdata;
    ld_pc4_p0   = pc_plus4;
    if (bus.Redirect) begin
      flush = 1'b1;
    end else begin
      unique case (state)
        FETCH: begin
          if (!bus.Stall) begin
            load  = bus.ImemReady;
            flush = !bus.ImemReady;
          end
        end
        HOLD: begin
          if (!bus.Stall) begin
            load        = 1'b1;
            ld_instr_p0 = buf_instr;
            ld_pc4_p0   = buf_pc4;
          end
        end
        DRAIN: begin
          flush = !bus.Stall;
        end
        default: begin
          flush = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= FETCH;
      pc    <= word_align(RESET_PC);
    end else if (bus.Redirect) begin
      pc <= redirect_pc;
      unique case (state)
        FETCH:   state <= bus.ImemReady ? FETCH : DRAIN;
        HOLD:    state <= FETCH;
        // A ready landing with the redirect still retires the killed request.
        DRAIN:   state <= bus.ImemReady ? FETCH : DRAIN;
        default: state <= FETCH;
      endcase
    end else begin
      unique case (state)
        FETCH: begin
          if (bus.ImemReady) begin
            pc <= pc_plus4;
            if (bus.Stall) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!bus.Stall) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (bus.ImemReady) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  // Holding buffer data; its validity is implied by state == HOLD.
  always_ff @(posedge Clk) begin
    if ((state == FETCH) && bus.ImemReady && bus.Stall && !bus.Redirect) begin
      buf_instr <= bus.ImemRdata;
      buf_pc4   <= pc_plus4;
    end
  end

  if_id_reg u_if_id (
    .clk      (Clk),
    .rst      (Rst),
    .load     (load),
    .flush    (flush),
    .instr_p0 (ld_instr_p0),
    .pc4_p0   (ld_pc4_p0),
    .instr_p1 (instr_p1),
    .pc4_p1   (pc4_p1),
    .vld_p1   (vld_p1)
  );

  assign bus.IfId_Instr   = instr_p1;
  assign bus.IfId_PCPlus4 = pc4_p1;
  assign bus.IfId_Valid   = vld_p1;
  assign bus.Opcode       = instr_p1[31:26];
  assign bus.Bit17        = instr_p1[16];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table followed by a random
// ready/stall stream checked against an in-order scoreboard of fetched words.
module tb_fetch_stage;

  typedef struct packed {
    logic        rst;
    logic        rdy;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_vld;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
  } vec_t;

  localparam int NV = 26;
  localparam int NR = 300;
  localparam logic [31:0] A = 32'h2000_0000;
  localparam logic [31:0] X = 32'hDEAD_BEEF;

  logic clk;
  logic rst;
  fetch_stage_if f();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests;
  int          fails;
  logic [63:0] sb[$];
  logic        prev_vld;
  logic [31:0] prev_instr;
  vec_t        vecs[NV];

  function automatic vec_t v(input logic r, input logic rd, input logic [31:0] dat,
                             input logic st, input logic rr, input logic [31:0] rp,
                             input logic eq, input logic [31:0] ea, input logic ev,
                             input logic [31:0] ei, input logic [31:0] ep);
    vec_t t;
    t = '{rst: r, rdy: rd, rdata: dat, stall: st, redir: rr, rpc: rp, exp_req: eq,
          exp_addr: ea, exp_vld: ev, exp_instr: ei, exp_pc4: ep};
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic rd, input logic [31:0] dat,
                       input logic st, input logic rr, input logic [31:0] rp);
    rst          = r;
    f.ImemReady  = rd;
    f.ImemRdata  = dat;
    f.Stall      = st;
    f.Redirect   = rr;
    f.RedirectPC = rp;
  endtask

  // Pop the scoreboard whenever IF/ID takes on a newly loaded instruction.
  task automatic sb_observe();
    logic [63:0] e;
    if (f.IfId_Valid && (!prev_vld || f.IfId_Instr != prev_instr)) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_empty: got %h expected no load", f.IfId_Instr);
      end else begin
        e = sb.pop_front();
        check("sb_instr", f.IfId_Instr, e[63:32]);
        check("sb_pc4", f.IfId_PCPlus4, e[31:0]);
      end
    end
    prev_vld   = f.IfId_Valid;
    prev_instr = f.IfId_Instr;
  endtask

  logic [31:0] m_pc, m_buf_i, m_buf_p, m_i, dat;
  logic        m_hold, m_v, rd, st;

  initial begin
    tests = 0;
    fails = 0;
    vecs[0]  = v(1, 0, 0,            0, 0, 0,            0, 32'h0,   0, 0, 0);
    vecs[1]  = v(1, 1, X,            0, 0, 0,            0, 32'h0,   0, 0, 0);
    vecs[2]  = v(0, 1, A,            0, 0, 0,            1, 32'h0,   1, A, 32'h4);
    vecs[3]  = v(0, 1, A | 32'h4,    0, 0, 0,            1, 32'h4,   1, A | 32'h4, 32'h8);
    vecs[4]  = v(0, 0, 0,            0, 0, 0,            1, 32'h8,   0, 0, 0);
    vecs[5]  = v(0, 0, 0,            0, 0, 0,            1, 32'h8,   0, 0, 0);
    vecs[6]  = v(0, 1, A | 32'h8,    0, 0, 0,            1, 32'h8,   1, A | 32'h8, 32'hC);
    vecs[7]  = v(0, 1, 32'h0401_0003, 1, 0, 0,           1, 32'hC,   1, A | 32'h8, 32'hC);
    vecs[8]  = v(0, 0, 0,            1, 0, 0,            0, 32'h10,  1, A | 32'h8, 32'hC);
    vecs[9]  = v(0, 1, X,            1, 0, 0,            0, 32'h10,  1, A | 32'h8, 32'hC);
    vecs[10] = v(0, 0, 0,            0, 0, 0,            0, 32'h10,  1, 32'h0401_0003, 32'h10);
    vecs[11] = v(0, 0, 0,            0, 0, 0,            1, 32'h10,  0, 0, 0);
    vecs[12] = v(0, 0, 0,            0, 1, 32'h103,      1, 32'h10,  0, 0, 0);
    vecs[13] = v(0, 1, X,            0, 0, 0,            0, 32'h100, 0, 0, 0);
    vecs[14] = v(0, 0, 0,            0, 0, 0,            1, 32'h100, 0, 0, 0);
    vecs[15] = v(0, 1, A | 32'h100,  0, 0, 0,            1, 32'h100, 1, A | 32'h100, 32'h104);
    vecs[16] = v(0, 1, 32'h0000_0020, 1, 0, 0,           1, 32'h104, 1, A | 32'h100, 32'h104);
    vecs[17] = v(0, 0, 0,            1, 1, 32'h200,      0, 32'h108, 0, 0, 0);
    vecs[18] = v(0, 0, 0,            0, 0, 0,            1, 32'h200, 0, 0, 0);
    vecs[19] = v(0, 0, 0,            0, 1, 32'h302,      1, 32'h200, 0, 0, 0);
    vecs[20] = v(1, 1, X,            0, 0, 0,            0, 32'h300, 0, 0, 0);
    vecs[21] = v(0, 0, 0,            0, 0, 0,            1, 32'h0,   0, 0, 0);
    vecs[22] = v(0, 1, A,            0, 0, 0,            1, 32'h0,   1, A, 32'h4);
    vecs[23] = v(0, 1, X,            0, 1, 32'hFFFF_FFFF, 1, 32'h4,  0, 0, 0);
    vecs[24] = v(0, 1, 32'h0800_0000, 0, 0, 0,           1, 32'hFFFF_FFFC, 1, 32'h0800_0000, 32'h0);
    vecs[25] = v(0, 1, 32'h0C00_0001, 0, 0, 0,           1, 32'h0,   1, 32'h0C00_0001, 32'h4);

    drive(1, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    prev_vld   = f.IfId_Valid;
    prev_instr = f.IfId_Instr;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].rdata, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
      @(negedge clk);
      check($sformatf("req[%0d]", i), 32'(f.ImemReq), 32'(vecs[i].exp_req));
      check($sformatf("addr[%0d]", i), f.ImemAddr, vecs[i].exp_addr);
      if (vecs[i].rst || vecs[i].redir) sb.delete();
      else if (vecs[i].rdy && vecs[i].exp_req) sb.push_back({vecs[i].rdata, vecs[i].exp_addr + 32'd4});
      @(posedge clk); #1;
      check($sformatf("valid[%0d]", i), 32'(f.IfId_Valid), 32'(vecs[i].exp_vld));
      check($sformatf("instr[%0d]", i), f.IfId_Instr, vecs[i].exp_instr);
      if (vecs[i].exp_vld) check($sformatf("pc4[%0d]", i), f.IfId_PCPlus4, vecs[i].exp_pc4);
      check($sformatf("opcode[%0d]", i), 32'(f.Opcode), 32'(vecs[i].exp_instr[31:26]));
      check($sformatf("bit17[%0d]", i), 32'(f.Bit17), 32'(vecs[i].exp_instr[16]));
      sb_observe();
    end

    // Random ready/stall stream without redirects, ending with an idle drain.
    m_pc   = 32'h4;
    m_hold = 1'b0;
    m_v    = 1'b1;
    m_i    = 32'h0C00_0001;
    m_buf_i = '0;
    m_buf_p = '0;
    for (int i = 0; i < NR + 3; i++) begin
      rd  = (i < NR) ? 1'($urandom_range(0, 1)) : 1'b0;
      st  = (i < NR) ? ($urandom_range(0, 2) == 0) : 1'b0;
      dat = 32'hA500_0000 | 32'(i);
      drive(0, rd, dat, st, 0, 0);
      @(negedge clk);
      check("rnd_req", 32'(f.ImemReq), 32'(!m_hold));
      check("rnd_addr", f.ImemAddr, m_pc);
      if (m_hold) begin
        if (!st) begin
          m_v = 1'b1; m_i = m_buf_i; m_hold = 1'b0;
        end
      end else if (rd) begin
        sb.push_back({dat, m_pc + 32'd4});
        if (!st) begin
          m_v = 1'b1; m_i = dat;
        end else begin
          m_buf_i = dat; m_buf_p = m_pc + 32'd4; m_hold = 1'b1;
        end
        m_pc = m_pc + 32'd4;
      end else if (!st) begin
        m_v = 1'b0; m_i = 32'h0;
      end
      @(posedge clk); #1;
      check("rnd_valid", 32'(f.IfId_Valid), 32'(m_v));
      check("rnd_instr", f.IfId_Instr, m_i);
      sb_observe();
    end
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
